// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
// It takes the EXE stage register outputs and runs loads and stores against a
// data memory over a req/ack handshake. While an access is outstanding it
// freezes the upstream pipeline with stall. Non-memory instructions pass to
// the MEM->WB register in one cycle.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   exe_*, Instruction_in           EXE stage register contents
//   stall                           combinational upstream hold
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack               memory response (single-cycle ack)
//   wb_*, Instruction               registered MEM->WB boundary
//
// state | meaning
// IDLE  | no access outstanding; EXE contents are accepted each cycle
// BUSY  | request on the bus, waiting for mem_ack; upstream is stalled
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_mem_read,
    input  logic              exe_mem_write,
    input  logic              exe_wb_en,
    input  logic [DATA_W-1:0] exe_alu_result,
    input  logic [DATA_W-1:0] exe_store_data,
    input  logic [REG_W-1:0]  exe_dest,
    input  logic [DATA_W-1:0] Instruction_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_wb_en,
    output logic              wb_mem_read,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] Instruction,
    output logic [REG_W-1:0]  wb_dest
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state, state_nxt;
    logic   memop;
    logic   accept;     // IDLE with a memory op: launch a request
    logic   complete;   // BUSY with ack: retire the held instruction
    logic   pass;       // IDLE without a memory op: straight pass-through

    assign memop = exe_valid & (exe_mem_read | exe_mem_write);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        pass      = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    pass = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory request registers: loaded on accept, frozen while BUSY.
    // A write wins when both read and write are flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= exe_mem_write;
            mem_addr  <= {exe_alu_result[DATA_W-1:2], 2'b00};
            mem_wdata <= exe_store_data;
        end else if (complete) begin
            mem_req <= 1'b0;
        end
    end

    // MEM->WB register. On completion the EXE inputs are still the ones that
    // launched the access because upstream has been held by stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_wb_en      <= 1'b0;
            wb_mem_read   <= 1'b0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            Instruction   <= '0;
            wb_dest       <= '0;
        end else if (pass || complete) begin
            wb_valid      <= exe_valid;
            wb_wb_en      <= exe_wb_en;
            wb_mem_read   <= exe_mem_read;
            wb_alu_result <= exe_alu_result;
            wb_mem_data   <= (complete && !mem_we) ? mem_rdata : '0;
            Instruction   <= Instruction_in;
            wb_dest       <= exe_dest;
        end else begin
            wb_valid      <= 1'b0;
            wb_wb_en      <= 1'b0;
            wb_mem_read   <= 1'b0;
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            Instruction   <= '0;
            wb_dest       <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        exe_valid;
    logic        exe_mem_read;
    logic        exe_mem_write;
    logic        exe_wb_en;
    logic [31:0] exe_alu_result;
    logic [31:0] exe_store_data;
    logic [3:0]  exe_dest;
    logic [31:0] Instruction_in;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_wb_en;
    logic        wb_mem_read;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic [31:0] Instruction;
    logic [3:0]  wb_dest;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .exe_valid      (exe_valid),
        .exe_mem_read   (exe_mem_read),
        .exe_mem_write  (exe_mem_write),
        .exe_wb_en      (exe_wb_en),
        .exe_alu_result (exe_alu_result),
        .exe_store_data (exe_store_data),
        .exe_dest       (exe_dest),
        .Instruction_in (Instruction_in),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .wb_valid       (wb_valid),
        .wb_wb_en       (wb_wb_en),
        .wb_mem_read    (wb_mem_read),
        .wb_alu_result  (wb_alu_result),
        .wb_mem_data    (wb_mem_data),
        .Instruction    (Instruction),
        .wb_dest        (wb_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge; outputs are then stable
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic we,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [3:0] dst, input logic [31:0] ins);
        exe_valid      = v;
        exe_mem_read   = rd;
        exe_mem_write  = wr;
        exe_wb_en      = we;
        exe_alu_result = alu;
        exe_store_data = sd;
        exe_dest       = dst;
        Instruction_in = ins;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        #2;
        // reset state
        chk("rst_stall",    {31'b0, stall},    32'h0);
        chk("rst_mem_req",  {31'b0, mem_req},  32'h0);
        chk("rst_mem_addr", mem_addr,          32'h0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("rst_wb_alu",   wb_alu_result,     32'h0);
        step();
        rst = 1'b0;
        step();
        chk("idle_stall", {31'b0, stall}, 32'h0);

        // ALU op passes through in one cycle
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 4'd3, 32'hAAAA_0001);
        #1 chk("alu_stall", {31'b0, stall}, 32'h0);
        step();
        chk("alu_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("alu_wb_en",    {31'b0, wb_wb_en}, 32'h1);
        chk("alu_result",   wb_alu_result,     32'h42);
        chk("alu_dest",     {28'b0, wb_dest},  32'h3);
        chk("alu_instr",    Instruction,       32'hAAAA_0001);
        chk("alu_memdata",  wb_mem_data,       32'h0);
        chk("alu_mem_req",  {31'b0, mem_req},  32'h0);

        // load, ack in first BUSY cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1006, 32'h0, 4'd5, 32'hBBBB_0002);
        #1 chk("ld_stall_acc", {31'b0, stall}, 32'h1);
        step();
        chk("ld_mem_req",  {31'b0, mem_req},  32'h1);
        chk("ld_mem_we",   {31'b0, mem_we},   32'h0);
        chk("ld_mem_addr", mem_addr,          32'h0000_1004);
        chk("ld_bubble",   {31'b0, wb_valid}, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1 chk("ld_stall_ack", {31'b0, stall}, 32'h0);
        step();
        mem_ack = 1'b0;
        chk("ld_wb_valid", {31'b0, wb_valid},    32'h1);
        chk("ld_wb_data",  wb_mem_data,          32'hDEAD_BEEF);
        chk("ld_wb_mrd",   {31'b0, wb_mem_read}, 32'h1);
        chk("ld_wb_dest",  {28'b0, wb_dest},     32'h5);
        chk("ld_wb_instr", Instruction,          32'hBBBB_0002);
        chk("ld_req_drop", {31'b0, mem_req},     32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        step();
        chk("bubble_wb_valid", {31'b0, wb_valid}, 32'h0);

        // store, ack after 3 stalled cycles
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2003, 32'h1234_5678, 4'd7, 32'hCCCC_0003);
        for (int i = 0; i < 3; i++) begin
            #1 chk("st_stall", {31'b0, stall}, 32'h1);
            step();
            chk("st_mem_req",   {31'b0, mem_req},  32'h1);
            chk("st_mem_we",    {31'b0, mem_we},   32'h1);
            chk("st_mem_addr",  mem_addr,          32'h0000_2000);
            chk("st_mem_wdata", mem_wdata,         32'h1234_5678);
            chk("st_bubble",    {31'b0, wb_valid}, 32'h0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1 chk("st_stall_ack", {31'b0, stall}, 32'h0);
        step();
        mem_ack = 1'b0;
        chk("st_wb_valid", {31'b0, wb_valid},    32'h1);
        chk("st_wb_data",  wb_mem_data,          32'h0);
        chk("st_wb_mrd",   {31'b0, wb_mem_read}, 32'h0);
        chk("st_wb_alu",   wb_alu_result,        32'h0000_2003);
        chk("st_req_drop", {31'b0, mem_req},     32'h0);

        // read and write both set: treated as a store
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3001, 32'h5555_AAAA, 4'd2, 32'hDDDD_0004);
        step();
        chk("rw_mem_we",    {31'b0, mem_we}, 32'h1);
        chk("rw_mem_addr",  mem_addr,        32'h0000_3000);
        chk("rw_mem_wdata", mem_wdata,       32'h5555_AAAA);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        chk("rw_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("rw_wb_data",  wb_mem_data,       32'h0);

        // back-to-back loads
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'd8, 32'hEEEE_0005);
        step();
        chk("b2b1_addr", mem_addr, 32'h0000_0010);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'd9, 32'hEEEE_0006);
        #1 chk("b2b2_stall_acc", {31'b0, stall}, 32'h1);
        chk("b2b1_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("b2b1_wb_data",  wb_mem_data,       32'h1111_1111);
        chk("b2b1_wb_dest",  {28'b0, wb_dest},  32'h8);
        step();
        chk("b2b2_mem_req", {31'b0, mem_req}, 32'h1);
        chk("b2b2_addr",    mem_addr,         32'h0000_0020);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        step();
        mem_ack = 1'b0;
        chk("b2b2_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("b2b2_wb_data",  wb_mem_data,       32'h2222_2222);
        chk("b2b2_wb_dest",  {28'b0, wb_dest},  32'h9);

        // async reset while BUSY
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h7777_7777, 4'd1, 32'hFFFF_0007);
        step();
        chk("ar_busy_req", {31'b0, mem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("ar_mem_req",   {31'b0, mem_req},  32'h0);
        chk("ar_mem_we",    {31'b0, mem_we},   32'h0);
        chk("ar_mem_addr",  mem_addr,          32'h0);
        chk("ar_mem_wdata", mem_wdata,         32'h0);
        chk("ar_wb_valid",  {31'b0, wb_valid}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        step();
        rst = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
        #1 chk("sp_stall", {31'b0, stall}, 32'h0);
        step();
        mem_ack = 1'b0;
        chk("sp_wb_valid", {31'b0, wb_valid}, 32'h0);
        chk("sp_wb_data",  wb_mem_data,       32'h0);
        chk("sp_mem_req",  {31'b0, mem_req},  32'h0);
        // still IDLE: an ALU op passes straight through
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 32'h0, 4'd4, 32'h1234_0008);
        #1 chk("post_stall", {31'b0, stall}, 32'h0);
        step();
        chk("post_wb_valid", {31'b0, wb_valid}, 32'h1);
        chk("post_wb_alu",   wb_alu_result,     32'h0000_0099);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
